// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM behavioural model: command encodings,
// bank and init state enums, violation codes and the mode-word check.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_MODE      = 3'b000,
    CMD_REFRESH   = 3'b001,
    CMD_PRECHARGE = 3'b010,
    CMD_ACTIVE    = 3'b011,
    CMD_WRITE     = 3'b100,
    CMD_READ      = 3'b101,
    CMD_STOP      = 3'b110,
    CMD_NOP       = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    BANK_IDLE,
    BANK_ACTIVE,
    BANK_PRECHARGING
  } bank_state_e;

  typedef enum logic [2:0] {
    INIT_PWRUP,
    INIT_PRE,
    INIT_MODE,
    INIT_REF1,
    INIT_READY
  } init_state_e;

  localparam logic [3:0] ERR_NONE           = 4'd0;
  localparam logic [3:0] ERR_BAD_INIT       = 4'd1;
  localparam logic [3:0] ERR_NOT_ACTIVE     = 4'd2;
  localparam logic [3:0] ERR_ALREADY_ACTIVE = 4'd3;
  localparam logic [3:0] ERR_T_RCD          = 4'd4;
  localparam logic [3:0] ERR_T_RP           = 4'd5;
  localparam logic [3:0] ERR_T_RC           = 4'd6;
  localparam logic [3:0] ERR_T_MRD          = 4'd7;
  localparam logic [3:0] ERR_BUS_CONFLICT   = 4'd8;
  localparam logic [3:0] ERR_BAD_MODE       = 4'd9;
  localparam logic [3:0] ERR_REF_ACTIVE     = 4'd10;

  // A mode word is accepted only for CAS latency 2 or 3 and burst length 1
  function automatic logic mode_ok(input logic [1:0] cl, input logic [2:0] bl);
    return (cl == 2'd2 || cl == 2'd3) && (bl == 3'b000);
  endfunction

endpackage

// File: rtl/sdram_model_bank.sv
// One SDRAM bank: IDLE / ACTIVE(row) / PRECHARGING state and the open row.
// With SDRAM_MODEL_TIMING_CHECK_EN defined it also keeps the per-bank
// RCD / RP / RC window counters and reports whether each window is open.
module sdram_model_bank
  import sdram_pkg::*;
#(
  parameter int ROWBITS = 11
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
  , parameter int T_RCD = 3
  , parameter int T_RP  = 3
  , parameter int T_RC  = 8
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  cmd_e               cmd,
  input  logic               sel,
  input  logic               pre_all,
  input  logic [ROWBITS-1:0] row,
  output bank_state_e        state,
  output logic [ROWBITS-1:0] open_row
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
  , output logic             rcd_busy
  , output logic             rp_busy
  , output logic             rc_busy
`endif
);

  logic open_cmd;
  logic close_cmd;

  assign open_cmd  = (cmd == CMD_ACTIVE) && sel;
  assign close_cmd = (cmd == CMD_PRECHARGE) && (sel || pre_all) && (state == BANK_ACTIVE);

  // Bank FSM: ACTIVE opens (or re-opens) a row, PRECHARGE of an idle bank is a no-op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BANK_IDLE;
      open_row <= '0;
    end else if (open_cmd) begin
      state    <= BANK_ACTIVE;
      open_row <= row;
    end else if (close_cmd) begin
      state <= BANK_PRECHARGING;
    end else if (state == BANK_PRECHARGING) begin
      state <= BANK_IDLE;
    end
  end

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
  logic [7:0] rcd_cnt;
  logic [7:0] rp_cnt;
  logic [7:0] rc_cnt;

  // Window counters load T-1 on the constraining command so a command k clocks later sees T-k
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcd_cnt <= 8'd0;
      rp_cnt  <= 8'd0;
      rc_cnt  <= 8'd0;
    end else begin
      rcd_cnt <= open_cmd  ? 8'(T_RCD - 1) : ((rcd_cnt != 8'd0) ? rcd_cnt - 8'd1 : 8'd0);
      rc_cnt  <= open_cmd  ? 8'(T_RC - 1)  : ((rc_cnt != 8'd0)  ? rc_cnt - 8'd1  : 8'd0);
      rp_cnt  <= close_cmd ? 8'(T_RP - 1)  : ((rp_cnt != 8'd0)  ? rp_cnt - 8'd1  : 8'd0);
    end
  end

  assign rcd_busy = (rcd_cnt != 8'd0);
  assign rp_busy  = (rp_cnt != 8'd0);
  assign rc_busy  = (rc_cnt != 8'd0);
`endif

endmodule

// File: rtl/sdram_model.sv
// Behavioural SDRAM device model with protocol checking: init sequence,
// per-bank row state, single-word reads with CAS latency 2/3, and a sticky
// first-violation error code. Defining SDRAM_MODEL_TIMING_CHECK_EN adds the
// tRCD / tRP / tRC / tMRD window checks.
module sdram_model
  import sdram_pkg::*;
#(
  parameter int BANKBITS = 1,
  parameter int ROWBITS  = 11,
  parameter int COLBITS  = 8,
  parameter int DWIDTH   = 16,
  parameter int MEMBITS  = 12,
  parameter int T_RCD    = 3,
  parameter int T_RP     = 3,
  parameter int T_RC     = 8,
  parameter int T_MRD    = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pin_ras_n,
  input  logic                        pin_cas_n,
  input  logic                        pin_we_n,
  input  logic [BANKBITS+ROWBITS-1:0] pin_addr,
  input  logic [DWIDTH-1:0]           pin_data_i,
  output logic [DWIDTH-1:0]           pin_data_o,
  output logic                        pin_data_oe,
  output logic                        err,
  output logic [3:0]                  err_code
);

  localparam int NBANKS = 1 << BANKBITS;

  // Parameter sanity guard: A10 must exist and every timing window is at least one clock
  if (ROWBITS < 11 || COLBITS > ROWBITS || T_RCD < 1 || T_RP < 1 || T_RC < 1 || T_MRD < 1) begin : g_bad_params
  end

  cmd_e                cmd;
  logic [BANKBITS-1:0] bank;
  logic [ROWBITS-1:0]  a;
  logic [COLBITS-1:0]  col;

  assign cmd  = cmd_e'({pin_ras_n, pin_cas_n, pin_we_n});
  assign bank = pin_addr[BANKBITS+ROWBITS-1:ROWBITS];
  assign a    = pin_addr[ROWBITS-1:0];
  assign col  = a[COLBITS-1:0];

  bank_state_e        bank_state [NBANKS];
  logic [ROWBITS-1:0] open_row   [NBANKS];
  logic [NBANKS-1:0]  bank_active;
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
  logic [NBANKS-1:0]  rcd_busy;
  logic [NBANKS-1:0]  rp_busy;
  logic [NBANKS-1:0]  rc_busy;
`endif

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    sdram_model_bank #(
      .ROWBITS(ROWBITS)
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
      , .T_RCD(T_RCD)
      , .T_RP (T_RP)
      , .T_RC (T_RC)
`endif
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .cmd     (cmd),
      .sel     (bank == BANKBITS'(b)),
      .pre_all (a[10]),
      .row     (a),
      .state   (bank_state[b]),
      .open_row(open_row[b])
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
      , .rcd_busy(rcd_busy[b])
      , .rp_busy (rp_busy[b])
      , .rc_busy (rc_busy[b])
`endif
    );
    assign bank_active[b] = (bank_state[b] == BANK_ACTIVE);
  end

  logic               is_rw;
  logic               rd_go;
  logic               read_pending;
  logic [MEMBITS-1:0] mem_idx;
  logic [DWIDTH-1:0]  mem [0:(1<<MEMBITS)-1];
  logic [DWIDTH-1:0]  rd_word;

  assign is_rw   = (cmd == CMD_READ) || (cmd == CMD_WRITE);
  assign rd_go   = (cmd == CMD_READ) && bank_active[bank];
  assign mem_idx = MEMBITS'({open_row[bank], bank, col});
  assign rd_word = mem[mem_idx];

  // Init FSM: walks PWRUP -> PRE -> MODE -> REF1 -> READY on the expected commands
  init_state_e init_state;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_state <= INIT_PWRUP;
    end else begin
      case (init_state)
        INIT_PWRUP: if (cmd == CMD_PRECHARGE && a[10]) init_state <= INIT_PRE;
        INIT_PRE:   if (cmd == CMD_MODE)               init_state <= INIT_MODE;
        INIT_MODE:  if (cmd == CMD_REFRESH)            init_state <= INIT_REF1;
        INIT_REF1:  if (cmd == CMD_REFRESH)            init_state <= INIT_READY;
        default:    init_state <= init_state;
      endcase
    end
  end

  logic init_ok;
  assign init_ok = (cmd == CMD_NOP) || (init_state == INIT_READY)
                || (init_state == INIT_PWRUP && cmd == CMD_PRECHARGE && a[10])
                || (init_state == INIT_PRE && cmd == CMD_MODE)
                || ((init_state == INIT_MODE || init_state == INIT_REF1) && cmd == CMD_REFRESH);

  // CAS latency register; only a legal latency (2 or 3) is taken from the mode word
  logic cl3;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cl3 <= 1'b0;
    end else if (cmd == CMD_MODE && a[5]) begin
      cl3 <= a[4];
    end
  end

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
  logic [7:0] mrd_cnt;
  logic [7:0] ref_cnt;

  // Device-wide windows after MODE and REFRESH, counted like the per-bank ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mrd_cnt <= 8'd0;
      ref_cnt <= 8'd0;
    end else begin
      mrd_cnt <= (cmd == CMD_MODE)    ? 8'(T_MRD - 1) : ((mrd_cnt != 8'd0) ? mrd_cnt - 8'd1 : 8'd0);
      ref_cnt <= (cmd == CMD_REFRESH) ? 8'(T_RC - 1)  : ((ref_cnt != 8'd0) ? ref_cnt - 8'd1 : 8'd0);
    end
  end
`endif

  // Violation decode for the command at this edge; earlier checks take priority
  logic [3:0] viol;
  always_comb begin
    viol = ERR_NONE;
    if (!init_ok) viol = ERR_BAD_INIT;
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
    if (viol == ERR_NONE && cmd != CMD_NOP && mrd_cnt != 8'd0)          viol = ERR_T_MRD;
    if (viol == ERR_NONE && cmd != CMD_NOP && ref_cnt != 8'd0)          viol = ERR_T_RC;
    if (viol == ERR_NONE && cmd == CMD_ACTIVE && rp_busy[bank])         viol = ERR_T_RP;
    if (viol == ERR_NONE && cmd == CMD_REFRESH && (|rp_busy))           viol = ERR_T_RP;
    if (viol == ERR_NONE && cmd == CMD_ACTIVE && rc_busy[bank])         viol = ERR_T_RC;
    if (viol == ERR_NONE && is_rw && rcd_busy[bank])                    viol = ERR_T_RCD;
`endif
    if (viol == ERR_NONE && is_rw && !bank_active[bank])                viol = ERR_NOT_ACTIVE;
    if (viol == ERR_NONE && cmd == CMD_WRITE && read_pending)           viol = ERR_BUS_CONFLICT;
    if (viol == ERR_NONE && cmd == CMD_ACTIVE && bank_active[bank])     viol = ERR_ALREADY_ACTIVE;
    if (viol == ERR_NONE && cmd == CMD_MODE && !mode_ok(a[5:4], a[2:0])) viol = ERR_BAD_MODE;
    if (viol == ERR_NONE && cmd == CMD_REFRESH && (|bank_active))       viol = ERR_REF_ACTIVE;
  end

  // Sticky error: only the first violation after reset is recorded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (!err && viol != ERR_NONE) begin
      err      <= 1'b1;
      err_code <= viol;
    end
  end

  // Storage array is never cleared; writes to a closed bank are dropped
  always_ff @(posedge clk) begin
    if (cmd == CMD_WRITE && bank_active[bank]) begin
      mem[mem_idx] <= pin_data_i;
    end
  end

  // Read pipeline: CL3 enters stage 0, CL2 enters stage 1, output register loads at edge n+CL
  logic [2:0]        pipe_v;
  logic [DWIDTH-1:0] pipe_d0;
  logic [DWIDTH-1:0] pipe_d1;
  logic [DWIDTH-1:0] pipe_d2;

  assign read_pending = |pipe_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_v      <= 3'b000;
      pin_data_oe <= 1'b0;
      pin_data_o  <= '0;
    end else begin
      pipe_v[0]   <= rd_go && cl3;
      pipe_v[1]   <= pipe_v[0] || (rd_go && !cl3);
      pipe_v[2]   <= pipe_v[1];
      pin_data_oe <= pipe_v[2];
      pin_data_o  <= pipe_v[2] ? pipe_d2 : '0;
    end
  end

  // Data side of the read pipeline carries no reset; the valid bits qualify it
  always_ff @(posedge clk) begin
    pipe_d0 <= rd_word;
    pipe_d1 <= pipe_v[0] ? pipe_d0 : rd_word;
    pipe_d2 <= pipe_d1;
  end

endmodule

// File: tb/tb_sdram_model.sv
// Self-checking bench for sdram_model: a directed vector table for the
// standard init / write / read flow plus hand-written multi-cycle sequences.
// Expectations for the timing windows follow SDRAM_MODEL_TIMING_CHECK_EN.
module tb_sdram_model;
  import sdram_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        ras_n = 1'b1;
  logic        cas_n = 1'b1;
  logic        we_n  = 1'b1;
  logic [11:0] addr  = 12'h000;
  logic [15:0] din   = 16'h0000;
  logic [15:0] dout;
  logic        oe;
  logic        err;
  logic [3:0]  code;

  int total  = 0;
  int passed = 0;

  sdram_model dut (
    .clk        (clk),
    .reset      (reset),
    .pin_ras_n  (ras_n),
    .pin_cas_n  (cas_n),
    .pin_we_n   (we_n),
    .pin_addr   (addr),
    .pin_data_i (din),
    .pin_data_o (dout),
    .pin_data_oe(oe),
    .err        (err),
    .err_code   (code)
  );

  always #5 clk = ~clk;

  typedef struct {
    cmd_e        cmd;
    logic [11:0] addr;
    logic [15:0] din;
    int          nops;
    logic        oe;
    logic [15:0] dout;
    logic        err;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs [21];

  // Drive one command at the falling edge; return just after the rising edge that samples it
  task automatic applyStimulus(input cmd_e c, input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    {ras_n, cas_n, we_n} = c;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic nopCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(CMD_NOP, 12'h000, 16'h0000);
  endtask

  // Data is compared only when the model is expected to drive the bus
  task automatic checkOutput(input string name, input logic eoe, input logic [15:0] edo,
                             input logic eerr, input logic [3:0] ecode);
    total++;
    if (oe === eoe && (!eoe || dout === edo) && err === eerr && code === ecode)
      passed++;
    else
      $display("[TB] FAIL %s: got oe=%0b data=%h err=%0b code=%0d, expected oe=%0b data=%h err=%0b code=%0d",
               name, oe, dout, err, code, eoe, edo, eerr, ecode);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    {ras_n, cas_n, we_n} = CMD_NOP;
    addr = 12'h000;
    din  = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic doInit(input logic [11:0] mode_word);
    applyStimulus(CMD_PRECHARGE, 12'h400, 16'h0);
    nopCycles(1);
    applyStimulus(CMD_MODE, mode_word, 16'h0);
    nopCycles(4);
    applyStimulus(CMD_REFRESH, 12'h000, 16'h0);
    nopCycles(9);
    applyStimulus(CMD_REFRESH, 12'h000, 16'h0);
    nopCycles(9);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{CMD_PRECHARGE, 12'h400, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[1]  = '{CMD_MODE,      12'h020, 16'h0000, 1, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[2]  = '{CMD_REFRESH,   12'h000, 16'h0000, 4, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[3]  = '{CMD_REFRESH,   12'h000, 16'h0000, 9, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[4]  = '{CMD_ACTIVE,    12'h005, 16'h0000, 9, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[5]  = '{CMD_WRITE,     12'h003, 16'hBEEF, 4, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[6]  = '{CMD_READ,      12'h003, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[7]  = '{CMD_NOP,       12'h000, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[8]  = '{CMD_NOP,       12'h000, 16'h0000, 0, 1'b1, 16'hBEEF, 1'b0, 4'd0};
    vecs[9]  = '{CMD_NOP,       12'h000, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[10] = '{CMD_PRECHARGE, 12'h000, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[11] = '{CMD_ACTIVE,    12'h802, 16'h0000, 3, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[12] = '{CMD_WRITE,     12'h807, 16'h1234, 3, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[13] = '{CMD_READ,      12'h807, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[14] = '{CMD_NOP,       12'h000, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[15] = '{CMD_NOP,       12'h000, 16'h0000, 0, 1'b1, 16'h1234, 1'b0, 4'd0};
    vecs[16] = '{CMD_NOP,       12'h000, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[17] = '{CMD_PRECHARGE, 12'h000, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[18] = '{CMD_READ,      12'h000, 16'h0000, 4, 1'b0, 16'h0000, 1'b1, 4'd2};
    vecs[19] = '{CMD_NOP,       12'h000, 16'h0000, 0, 1'b0, 16'h0000, 1'b1, 4'd2};
    vecs[20] = '{CMD_NOP,       12'h000, 16'h0000, 0, 1'b0, 16'h0000, 1'b1, 4'd2};

    doReset();
    checkOutput("reset_state", 1'b0, 16'h0000, 1'b0, 4'd0);
    total++;
    if (dout === 16'h0000) passed++;
    else $display("[TB] FAIL reset_dout: got data=%h, expected data=0000", dout);

    for (int i = 0; i < 21; i++) begin
      nopCycles(vecs[i].nops);
      applyStimulus(vecs[i].cmd, vecs[i].addr, vecs[i].din);
      checkOutput($sformatf("vec%0d", i), vecs[i].oe, vecs[i].dout, vecs[i].err, vecs[i].code);
    end

    // ACTIVE straight out of reset breaks the init sequence
    doReset();
    checkOutput("reset_again", 1'b0, 16'h0000, 1'b0, 4'd0);
    applyStimulus(CMD_ACTIVE, 12'h005, 16'h0);
    checkOutput("act_before_init", 1'b0, 16'h0000, 1'b1, 4'd1);

    // Mode word with burst length other than 1
    doReset();
    applyStimulus(CMD_PRECHARGE, 12'h400, 16'h0);
    nopCycles(1);
    applyStimulus(CMD_MODE, 12'h021, 16'h0);
    checkOutput("bad_mode", 1'b0, 16'h0000, 1'b1, 4'd9);

    // CL=3 back-to-back reads of columns 0..3
    doReset();
    doInit(12'h030);
    checkOutput("init_cl3", 1'b0, 16'h0000, 1'b0, 4'd0);
    applyStimulus(CMD_ACTIVE, 12'h001, 16'h0);
    nopCycles(3);
    for (int i = 0; i < 4; i++) applyStimulus(CMD_WRITE, 12'(i), 16'(16'h10 + i));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(CMD_READ, 12'(i), 16'h0);
      if (i == 3) checkOutput("burst_rd0", 1'b1, 16'h0010, 1'b0, 4'd0);
      else        checkOutput($sformatf("burst_wait%0d", i), 1'b0, 16'h0000, 1'b0, 4'd0);
    end
    for (int i = 1; i < 4; i++) begin
      applyStimulus(CMD_NOP, 12'h000, 16'h0);
      checkOutput($sformatf("burst_rd%0d", i), 1'b1, 16'(16'h10 + i), 1'b0, 4'd0);
    end
    applyStimulus(CMD_NOP, 12'h000, 16'h0);
    checkOutput("burst_end", 1'b0, 16'h0000, 1'b0, 4'd0);

    // READ one clock after ACTIVE
    doReset();
    doInit(12'h020);
    applyStimulus(CMD_ACTIVE, 12'h005, 16'h0);
    applyStimulus(CMD_READ, 12'h003, 16'h0);
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
    checkOutput("rcd_short", 1'b0, 16'h0000, 1'b1, 4'd4);
`else
    checkOutput("rcd_short", 1'b0, 16'h0000, 1'b0, 4'd0);
`endif

    // READ exactly T_RCD clocks after ACTIVE; memory survived the resets
    doReset();
    doInit(12'h020);
    applyStimulus(CMD_ACTIVE, 12'h005, 16'h0);
    nopCycles(2);
    applyStimulus(CMD_READ, 12'h003, 16'h0);
    checkOutput("rcd_exact", 1'b0, 16'h0000, 1'b0, 4'd0);
    nopCycles(1);
    applyStimulus(CMD_NOP, 12'h000, 16'h0);
    checkOutput("rcd_exact_data", 1'b1, 16'hBEEF, 1'b0, 4'd0);

    // PRECHARGE of an idle bank is fine, ACTIVE on an open bank is not
    doReset();
    doInit(12'h020);
    applyStimulus(CMD_ACTIVE, 12'h005, 16'h0);
    nopCycles(9);
    applyStimulus(CMD_PRECHARGE, 12'h800, 16'h0);
    checkOutput("pre_idle_bank", 1'b0, 16'h0000, 1'b0, 4'd0);
    applyStimulus(CMD_ACTIVE, 12'h006, 16'h0);
    checkOutput("act_on_active", 1'b0, 16'h0000, 1'b1, 4'd3);

    // WRITE while a CL=3 read is pending, then a second violation keeps the code
    doReset();
    doInit(12'h030);
    applyStimulus(CMD_ACTIVE, 12'h000, 16'h0);
    nopCycles(3);
    applyStimulus(CMD_READ, 12'h000, 16'h0);
    checkOutput("read_before_conflict", 1'b0, 16'h0000, 1'b0, 4'd0);
    applyStimulus(CMD_WRITE, 12'h000, 16'h5555);
    checkOutput("bus_conflict", 1'b0, 16'h0000, 1'b1, 4'd8);
    applyStimulus(CMD_ACTIVE, 12'h800, 16'h0);
    nopCycles(3);
    applyStimulus(CMD_REFRESH, 12'h000, 16'h0);
    checkOutput("sticky_code", 1'b0, 16'h0000, 1'b1, 4'd8);

    // REFRESH with a bank open
    doReset();
    doInit(12'h020);
    applyStimulus(CMD_ACTIVE, 12'h000, 16'h0);
    nopCycles(9);
    applyStimulus(CMD_REFRESH, 12'h000, 16'h0);
    checkOutput("ref_active", 1'b0, 16'h0000, 1'b1, 4'd10);

    // Reset asserted while the read pipeline holds words
    doReset();
    doInit(12'h030);
    applyStimulus(CMD_ACTIVE, 12'h005, 16'h0);
    nopCycles(3);
    applyStimulus(CMD_READ, 12'h003, 16'h0);
    applyStimulus(CMD_READ, 12'h003, 16'h0);
    applyStimulus(CMD_NOP, 12'h000, 16'h0);
    checkOutput("pre_reset_wait", 1'b0, 16'h0000, 1'b0, 4'd0);
    applyStimulus(CMD_NOP, 12'h000, 16'h0);
    checkOutput("pre_reset_data", 1'b1, 16'hBEEF, 1'b0, 4'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_read", 1'b0, 16'h0000, 1'b0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(CMD_NOP, 12'h000, 16'h0);
      checkOutput($sformatf("after_reset%0d", i), 1'b0, 16'h0000, 1'b0, 4'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
